pipe_adder_sched: RTL

//  Shares one pipe_adder instance between N requesters. Round-robin arbiter issues

---
 rtl/pipe_adder_sched_pkg.sv | 17 +
 rtl/pipe_adder_rr_arb.sv | 32 +++
 rtl/pipe_adder_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_adder_sched_pkg.sv
// Shared types and helpers for the shared pipelined-adder scheduler.
package pipe_adder_sched_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  typedef logic [$clog2(DEF_N)-1:0] id_t;

  function automatic int unsigned next_ptr(
    input int unsigned g,
    input int unsigned n
  );
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/pipe_adder_rr_arb.sv
// Round-robin grant: first active request at or after ptr, wrapping.
module pipe_adder_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] id,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + 32'(k)) % N);
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

endmodule

// File: rtl/pipe_adder_sched.sv
// Shares one pipelined adder among N requesters; in-order responses
// tagged with the owning requester id.
module pipe_adder_sched
  import pipe_adder_sched_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*DATA_W-1:0]   req_x_0,
  input  logic [N*DATA_W-1:0]   req_x_1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(N)-1:0]  rsp_id,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  add_req,
  output logic [DATA_W-1:0]     add_x_0,
  output logic [DATA_W-1:0]     add_x_1,
  output logic                  add_stall,
  output logic                  add_flush,
  input  logic [DATA_W-1:0]     add_result,
  input  logic                  add_vld,
  output logic                  err_o
);

  localparam int IW = $clog2(N);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] gid;
  logic [N-1:0]  grant;
  logic          any;
  logic          issue_ok;
  logic          empty;
  logic          capture;

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign add_stall = rsp_valid & ~rsp_ready;
  assign add_flush = flush_i;
  assign empty     = (count == '0);

  // Full blocks issue even when a pop happens this cycle.
  assign issue_ok = ~reset & ~flush_i & ~add_stall
                  & (count < CW'(DEPTH));

  assign capture = add_vld & ~add_stall & ~flush_i & ~empty;

  pipe_adder_rr_arb #(.N(N)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (issue_ok),
    .grant (grant),
    .id    (gid),
    .any   (any)
  );

  assign req_ready = grant;
  assign add_req   = any;

  always_comb begin
    add_x_0 = '0;
    add_x_1 = '0;
    for (int i = 0; i < N; i++) begin
      if (any && gid == IW'(i)) begin
        add_x_0 = req_x_0[i*DATA_W +: DATA_W];
        add_x_1 = req_x_1[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (any && !flush_i) mem[wr_ptr] <= gid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (any)     wr_ptr <= bump(wr_ptr);
      if (capture) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(any) - CW'(capture);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      err_o      <= 1'b0;
    end else begin
      if (any) ptr <= IW'(next_ptr(32'(gid), N));
      if (add_vld && empty) err_o <= 1'b1;
      if (flush_i) begin
        rsp_valid <= 1'b0;
      end else if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= add_result;
        rsp_id     <= mem[rd_ptr];
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
